decode_check_aligner: RTL
=========================

Name: decode_check_aligner

Overview:
- Sequences the decoder compare path: buffers golden-model decode results in a FIFO and pairs each with the DUT decoder result carrying the same PC.
- Drives a single-cycle, aligned compare strobe plus both field sets into decoder_scoreboard's valid/dut_*/gold_* inputs.
- Sits in TOP_CORE verification between the golden decoder model, the DUT decode-stage tap and the scoreboard.
- Detects ordering loss: PC mismatch, underflow, overflow attempt and timeout.

Parameters:
- DEPTH, 8, golden FIFO entries; power of two, >=2.
- TIMEOUT, 64, cycles a non-empty FIFO may wait for a DUT result before error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- gold_valid  in  1  golden result offered.
- gold_ready  out  1  FIFO can accept a golden result.
- gold_pc  in  32  golden PC.
- gold_fields  in  111  {rd[4:0], rs1[4:0], rs2[4:0], imm[31:0], Single_Instruction[63:0]}.
- dut_valid  in  1  DUT decode result present this cycle; no backpressure.
- dut_pc  in  32  DUT PC.
- dut_fields  in  111  same packing as gold_fields.
- dut_instruction  in  32  raw instruction word.
- drain_req  in  1  pulse: stop accepting golden results and empty the FIFO.
- cmp_valid  out  1  aligned pair valid; drives scoreboard valid.
- cmp_pc  out  32  PC of the pair.
- cmp_dut_fields  out  111  registered DUT fields.
- cmp_gold_fields  out  111  registered golden fields.
- cmp_instruction  out  32  registered raw instruction.
- drain_done  out  1  one-cycle pulse when the drain completes.
- err_pc  out  1  sticky PC mismatch.
- err_underflow  out  1  sticky; dut_valid with no golden available.
- err_timeout  out  1  sticky.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- cmp_count  out  32  compares issued; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (async, immediate): all outputs 0, FIFO empty, state IDLE; any in-flight compare is dropped.
- States:
  - IDLE: go to RUN on first accepted gold_valid or dut_valid.
  - RUN: normal pairing.
  - DRAIN: entered on drain_req from IDLE/RUN. gold_ready=0; DUT pops continue. When level==0, pulse drain_done, return to IDLE.
  - ERROR: terminal until rst. gold_ready=0, cmp_valid=0, FIFO frozen.
- gold_ready = !full in IDLE/RUN. Push when gold_valid && gold_ready. No push while full, even if a pop occurs in the same cycle.
- Pop on dut_valid when level>0. Registered outputs update next cycle: cmp_valid=1 for exactly one cycle, cmp_pc=dut_pc. Latency is 1 cycle from dut_valid.
- Empty-FIFO bypass: if level==0 and a gold push occurs in the same cycle as dut_valid, pair directly and do not write the FIFO.
- dut_valid with level==0 and no bypass: set err_underflow, go to ERROR, no compare.
- Pair with gold_pc != dut_pc: set err_pc, go to ERROR. That pair is still issued (cmp_valid=1) so the scoreboard logs the mismatch.
- Timeout counter:
  - Clears on every pop and whenever level==0.
  - Otherwise increments each cycle.
  - Reaching TIMEOUT sets err_timeout and goes to ERROR.
- Pointers are log2(DEPTH) bits and wrap naturally; level carries the extra bit to tell full from empty.
- cmp_count increments on each cmp_valid.
- drain_req while in ERROR is ignored. drain_req while already in DRAIN has no effect.

Optional Feature:
- DECODE_ALIGN_TRACE_EN defined:
  - $display "[ALIGN @ PC=%h] lvl=%0d" on every issued compare.
  - On error entry, display error type, both PCs and level.
- DECODE_ALIGN_TRACE_EN undefined: no simulation output; logic is identical.

Decomposition:
- Package decode_align_pkg:
  - decode_fields_t packed struct (rd, rs1, rs2, imm, Single_Instruction), 111 bits.
  - align_state_e enum {IDLE, RUN, DRAIN, ERROR}.
  - Constant FIELDS_W = 111.
- One sub-module: decode_align_fifo. Parameterised sync FIFO of {pc, decode_fields_t} with push/pop/full/empty/level. The top holds the FSM, bypass, timeout and error logic.

Test Plan:
- In-order stream: push golden PCs 0x0,0x4,0x8; dut_valid at the same PCs on cycles 5,6,7 -> cmp_valid on cycles 6,7,8 with matching cmp_pc, cmp_count=3, all err_* = 0.
- Bypass: level 0, gold_valid and dut_valid same cycle, PC 0x100 -> cmp_valid next cycle, level stays 0.
- Full: DEPTH=8, push 9 golden results with no DUT -> gold_ready=0 after 8 pushes, level=8. One dut_valid -> gold_ready returns to 1 the following cycle.
- PC mismatch: golden 0x20, DUT 0x24 -> cmp_valid pulse with cmp_pc=0x24, err_pc=1, state ERROR, gold_ready=0 thereafter.
- Timeout: push 1 golden, no dut_valid for 64 cycles -> err_timeout=1 on cycle 64. Separately, dut_valid at level 0 -> err_underflow=1.
- Drain and reset: 3 entries buffered, drain_req, 3 dut_valids -> drain_done pulse, back to IDLE. Assert rst mid-drain -> all outputs 0 immediately, level=0.

Source files
------------

// File: rtl/decode_align_pkg.sv
// -----------------------------------------------------------------------------
// decode_align_pkg
// Shared types for the decoder compare-path aligner.
//   FIELDS_W        : width of one packed decode result (111 bits)
//   decode_fields_t : {rd, rs1, rs2, imm, Single_Instruction}
//   gold_entry_t    : one buffered golden result {pc, fields}
//   align_state_e   : aligner sequencing states
//   sat_inc32       : saturating 32-bit increment used by the compare counter
// -----------------------------------------------------------------------------
package decode_align_pkg;

  localparam int FIELDS_W = 111;
  localparam int PC_W     = 32;
  localparam int ENTRY_W  = PC_W + FIELDS_W;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [63:0] Single_Instruction;
  } decode_fields_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    decode_fields_t  fields;
  } gold_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ERROR = 2'd3
  } align_state_e;

  // Counter that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/decode_align_fifo.sv
// -----------------------------------------------------------------------------
// decode_align_fifo
// Synchronous show-ahead FIFO holding golden decode results {pc, fields}.
// The head entry is visible on dout while not empty so the aligner can pair
// it with a DUT result in the same cycle the pop is requested.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (pointers/level only)
//   push, din    : write request and data (ignored while full)
//   pop          : read request (ignored while empty)
//   dout         : current head entry
//   full, empty  : occupancy flags
//   level        : occupancy, one bit wider than the pointers
// -----------------------------------------------------------------------------
module decode_align_fifo
  import decode_align_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  gold_entry_t              din,
  input  logic                     pop,
  output gold_entry_t              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  gold_entry_t     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset: contents are only meaningful below level.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decode_check_aligner.sv
// -----------------------------------------------------------------------------
// decode_check_aligner
// Pairs buffered golden-model decode results with DUT decode-stage results of
// the same PC and presents them, registered and aligned, to the decoder
// scoreboard. Ordering loss (PC mismatch, underflow, timeout) is latched and
// freezes the block in a terminal error state until reset.
//
// Optional build macro: DECODE_ALIGN_TRACE_EN enables simulation trace output
// on every issued compare and on error entry; logic is identical either way.
//
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   gold_valid/gold_ready            : golden result handshake
//   gold_pc, gold_fields             : golden result payload
//   dut_valid, dut_pc, dut_fields    : DUT result (no backpressure)
//   dut_instruction                  : raw instruction word of the DUT result
//   drain_req                        : pulse, stop intake and empty the FIFO
//   cmp_valid, cmp_pc, cmp_*_fields,
//   cmp_instruction                  : aligned compare strobe and payload
//   drain_done                       : one-cycle pulse when drain finishes
//   err_pc, err_underflow,
//   err_timeout                      : sticky error flags
//   level                            : FIFO occupancy
//   cmp_count                        : saturating count of compares issued
// -----------------------------------------------------------------------------
module decode_check_aligner
  import decode_align_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    gold_valid,
  output logic                    gold_ready,
  input  logic [31:0]             gold_pc,
  input  logic [FIELDS_W-1:0]     gold_fields,
  input  logic                    dut_valid,
  input  logic [31:0]             dut_pc,
  input  logic [FIELDS_W-1:0]     dut_fields,
  input  logic [31:0]             dut_instruction,
  input  logic                    drain_req,
  output logic                    cmp_valid,
  output logic [31:0]             cmp_pc,
  output logic [FIELDS_W-1:0]     cmp_dut_fields,
  output logic [FIELDS_W-1:0]     cmp_gold_fields,
  output logic [31:0]             cmp_instruction,
  output logic                    drain_done,
  output logic                    err_pc,
  output logic                    err_underflow,
  output logic                    err_timeout,
  output logic [$clog2(DEPTH):0]  level,
  output logic [31:0]             cmp_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  align_state_e  state;
  align_state_e  state_next;
  logic          drain_done_next;

  gold_entry_t   gold_entry;
  gold_entry_t   fifo_head;
  gold_entry_t   pair_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;

  logic          active;
  logic          accepting;
  logic          gold_take;
  logic          bypass;
  logic          pair;
  logic          underflow_evt;
  logic          mismatch_evt;
  logic          timeout_evt;
  logic          err_evt;
  logic          tmo_clear;
  logic [TW-1:0] tmo_cnt;

  assign gold_entry = {gold_pc, gold_fields};

  decode_align_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (gold_entry),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // ---------------------------------------------------------------------------
  // Datapath control: intake, pairing, bypass and error detection.
  // ERROR freezes everything, including the FIFO and the timeout counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    active     = (state != ERROR);
    accepting  = (state == IDLE) || (state == RUN);
    // Held low while reset is asserted so every output reads zero in reset.
    gold_ready = !rst && accepting && !fifo_full;
    gold_take  = gold_valid && gold_ready;

    // With nothing buffered, a golden result arriving alongside its DUT
    // partner is paired directly and never lands in the FIFO.
    bypass     = active && fifo_empty && gold_take && dut_valid;
    fifo_pop   = active && dut_valid && !fifo_empty;
    fifo_push  = gold_take && !bypass;
    pair       = fifo_pop || bypass;
    pair_entry = bypass ? gold_entry : fifo_head;

    underflow_evt = active && dut_valid && fifo_empty && !bypass;
    // A mismatching pair is still issued so the scoreboard records it.
    mismatch_evt  = pair && (pair_entry.pc != dut_pc);

    // The counter tracks how long the current head has been waiting.
    tmo_clear   = fifo_pop || fifo_empty;
    timeout_evt = active && !tmo_clear && (tmo_cnt == TW'(TIMEOUT - 1));

    err_evt = underflow_evt || mismatch_evt || timeout_evt;
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM: next state and drain completion.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    drain_done_next = 1'b0;
    case (state)
      IDLE: begin
        if (err_evt) begin
          state_next = ERROR;
        end else if (drain_req) begin
          state_next = DRAIN;
        end else if (gold_take || dut_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (err_evt) begin
          state_next = ERROR;
        end else if (drain_req) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // A repeated drain_req here is deliberately ignored.
        if (err_evt) begin
          state_next = ERROR;
        end else if (fifo_empty) begin
          drain_done_next = 1'b1;
          state_next      = IDLE;
        end
      end
      ERROR: begin
        state_next = ERROR;
      end
      default: begin
        state_next = ERROR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered state and outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      tmo_cnt         <= '0;
      cmp_valid       <= 1'b0;
      cmp_pc          <= '0;
      cmp_dut_fields  <= '0;
      cmp_gold_fields <= '0;
      cmp_instruction <= '0;
      cmp_count       <= '0;
      drain_done      <= 1'b0;
      err_pc          <= 1'b0;
      err_underflow   <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      state      <= state_next;
      drain_done <= drain_done_next;
      cmp_valid  <= pair;

      // Payload holds its last value between compares.
      if (pair) begin
        cmp_pc          <= dut_pc;
        cmp_dut_fields  <= dut_fields;
        cmp_gold_fields <= pair_entry.fields;
        cmp_instruction <= dut_instruction;
        cmp_count       <= sat_inc32(cmp_count);
      end

      if (active) begin
        tmo_cnt <= tmo_clear ? '0 : tmo_cnt + TW'(1);
      end

      err_pc        <= err_pc        | mismatch_evt;
      err_underflow <= err_underflow | underflow_evt;
      err_timeout   <= err_timeout   | timeout_evt;
    end
  end

`ifdef DECODE_ALIGN_TRACE_EN
  always @(posedge clk) begin
    if (!rst && pair) begin
      $display("[ALIGN @ PC=%h] lvl=%0d", dut_pc, level);
    end
    if (!rst && err_evt) begin
      $display("[ALIGN ERROR] type=%s gold_pc=%h dut_pc=%h lvl=%0d",
               underflow_evt ? "UNDERFLOW" : (mismatch_evt ? "PC_MISMATCH" : "TIMEOUT"),
               pair_entry.pc, dut_pc, level);
    end
  end
`else
  // Trace disabled: no simulation output is produced.
`endif

endmodule
